// File: rtl/apu_div_issue_queue.sv
// rtl/apu_div_issue_queue.sv - request FIFO and one-at-a-time issue sequencer for the shared divider
// Optional same-cycle issue of a request into an idle, empty queue: DIV_ISSUE_BYPASS_EN
module apu_div_issue_queue #(
   parameter int TAG_WIDTH = 5,
   parameter int DEPTH     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_i,
   output logic                     gnt_o,
   input  logic [2:0]               op_i,
   input  logic [31:0]              opa_i,
   input  logic [31:0]              opb_i,
   input  logic [TAG_WIDTH-1:0]     tag_i,
   output logic                     div_en_o,
   output logic [2:0]               div_op_o,
   output logic [31:0]              div_opa_o,
   output logic [31:0]              div_opb_o,
   output logic [TAG_WIDTH-1:0]     div_tag_o,
   input  logic                     div_ready_i,
   input  logic                     div_valid_i,
   input  logic [31:0]              div_res_i,
   input  logic [TAG_WIDTH-1:0]     div_tag_i,
   output logic                     rvalid_o,
   input  logic                     rready_i,
   output logic [31:0]              rdata_o,
   output logic [TAG_WIDTH-1:0]     rtag_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state_q, state_d;
   logic [2:0]            op_mem  [DEPTH];
   logic [31:0]           opa_mem [DEPTH];
   logic [31:0]           opb_mem [DEPTH];
   logic [TAG_WIDTH-1:0]  tag_mem [DEPTH];
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [CW-1:0]         cnt_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_q;
   logic [TAG_WIDTH-1:0]  rtag_q;
   logic                  slot_ok, fifo_issue, byp_issue, issue, push, load;

   // The result slot may be refilled in the same cycle it drains
   assign slot_ok    = ~rvalid_q | rready_i;
   assign fifo_issue = (state_q == IDLE) & (cnt_q != '0) & div_ready_i & slot_ok;
`ifdef DIV_ISSUE_BYPASS_EN
   assign byp_issue  = (state_q == IDLE) & (cnt_q == '0) & div_ready_i & slot_ok & req_i;
`else
   assign byp_issue  = 1'b0;
`endif
   assign issue      = fifo_issue | byp_issue;
   assign gnt_o      = (cnt_q != CW'(DEPTH));
   assign push       = req_i & gnt_o & ~byp_issue;
   assign load       = (state_q == BUSY) & div_valid_i;

   always_comb begin
      state_d  = state_q;
      div_en_o = 1'b0;
      case (state_q)
         IDLE: begin
            div_en_o = issue;
            if (issue) state_d = BUSY;
         end
         BUSY: begin
            if (div_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_op_o  = '0;
      div_opa_o = '0;
      div_opb_o = '0;
      div_tag_o = '0;
      if (byp_issue) begin
         div_op_o  = op_i;
         div_opa_o = opa_i;
         div_opb_o = opb_i;
         div_tag_o = tag_i;
      end else if (cnt_q != '0) begin
         div_op_o  = op_mem[rptr_q];
         div_opa_o = opa_mem[rptr_q];
         div_opb_o = opb_mem[rptr_q];
         div_tag_o = tag_mem[rptr_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         op_mem[wptr_q]  <= op_i;
         opa_mem[wptr_q] <= opa_i;
         opb_mem[wptr_q] <= opb_i;
         tag_mem[wptr_q] <= tag_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rtag_q   <= '0;
      end else begin
         state_q  <= state_d;
         if (push)       wptr_q <= wptr_q + PW'(1);
         if (fifo_issue) rptr_q <= rptr_q + PW'(1);
         cnt_q    <= cnt_q + CW'(push) - CW'(fifo_issue);
         rvalid_q <= load | (rvalid_q & ~rready_i);
         if (load) begin
            rdata_q <= div_res_i;
            rtag_q  <= div_tag_i;
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign rtag_o   = rtag_q;
   assign cnt_o    = cnt_q;

`ifndef SYNTHESIS
   idle_valid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !((state_q == IDLE) && div_valid_i))
      else $error("div_valid_i while idle");
`endif
endmodule

// File: tb/tb_apu_div_issue_queue.sv
// tb/tb_apu_div_issue_queue.sv - directed vector and sequence bench for apu_div_issue_queue
`timescale 1ns/1ps
module tb_apu_div_issue_queue;
   localparam int TW = 5;

   logic          clk = 1'b0, rst_n;
   logic          req_i, gnt_o, div_en_o, div_ready_i, div_valid_i, rvalid_o, rready_i;
   logic [2:0]    op_i, div_op_o;
   logic [31:0]   opa_i, opb_i, div_opa_o, div_opb_o, div_res_i, rdata_o;
   logic [TW-1:0] tag_i, div_tag_o, div_tag_i, rtag_o;
   logic [2:0]    cnt_o;
   int            errors = 0, checks = 0;

   always #5 clk = ~clk;

   apu_div_issue_queue #(.TAG_WIDTH(TW), .DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o), .op_i(op_i),
      .opa_i(opa_i), .opb_i(opb_i), .tag_i(tag_i), .div_en_o(div_en_o),
      .div_op_o(div_op_o), .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
      .div_tag_o(div_tag_o), .div_ready_i(div_ready_i), .div_valid_i(div_valid_i),
      .div_res_i(div_res_i), .div_tag_i(div_tag_i), .rvalid_o(rvalid_o),
      .rready_i(rready_i), .rdata_o(rdata_o), .rtag_o(rtag_o), .cnt_o(cnt_o));

   typedef struct {
      logic req; logic [31:0] opa, opb; logic [TW-1:0] tag;
      logic dready, dvalid; logic [31:0] dres; logic rready;
      logic e_gnt, e_den; logic [31:0] e_dopa; logic [TW-1:0] e_dtag;
      logic [2:0] e_cnt; logic e_rvalid; logic [31:0] e_rdata; logic [TW-1:0] e_rtag;
   } vec_t;

   function automatic vec_t v(logic req, logic [31:0] opa, logic [31:0] opb, logic [TW-1:0] tag,
                              logic dready, logic dvalid, logic [31:0] dres, logic rready,
                              logic gnt, logic den, logic [31:0] dopa, logic [TW-1:0] dtag,
                              logic [2:0] cnt, logic rvalid, logic [31:0] rdata, logic [TW-1:0] rtag);
      vec_t r;
      r.req = req; r.opa = opa; r.opb = opb; r.tag = tag; r.dready = dready; r.dvalid = dvalid;
      r.dres = dres; r.rready = rready; r.e_gnt = gnt; r.e_den = den; r.e_dopa = dopa;
      r.e_dtag = dtag; r.e_cnt = cnt; r.e_rvalid = rvalid; r.e_rdata = rdata; r.e_rtag = rtag;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_i = 0; op_i = 0; opa_i = 0; opb_i = 0; tag_i = 0;
      div_ready_i = 0; div_valid_i = 0; div_res_i = 0; div_tag_i = 0; rready_i = 1;
   endtask

   task automatic do_reset();
      @(negedge clk); idle_inputs(); rst_n = 0;
      @(negedge clk); @(negedge clk); rst_n = 1;
   endtask

   // Drives a stream of n requests against a 4-cycle divider model and checks issue/result order
   task automatic run_stream(input int n, input int rr_start);
      int sent = 0, issued = 0, got = 0, busy = 0, cyc = 0;
      logic [31:0]   r_res = 0;
      logic [TW-1:0] r_tag = 0;
      while (got < n && cyc < 500) begin
         @(negedge clk);
         req_i = (sent < n); op_i = 3'd1; tag_i = TW'(sent);
         opa_i = 32'(1000 + sent * 37); opb_i = 32'(sent + 2);
         div_valid_i = (busy == 1); div_res_i = r_res; div_tag_i = r_tag;
         div_ready_i = (busy == 0); rready_i = (cyc >= rr_start);
         #1;
         if (rvalid_o && !rready_i) chk("issue_held", div_en_o, 0);
         if (div_en_o) begin
            chk($sformatf("issue%0d_tag", issued), div_tag_o, 32'(issued));
            chk($sformatf("issue%0d_opa", issued), div_opa_o, 32'(1000 + issued * 37));
            r_res = div_opa_o / div_opb_o; r_tag = div_tag_o; busy = 4; issued++;
         end else if (busy > 0) busy--;
         if (rvalid_o && rready_i) begin
            chk($sformatf("res%0d_tag", got), rtag_o, 32'(got));
            chk($sformatf("res%0d_data", got), rdata_o, 32'((1000 + got * 37) / (got + 2)));
            got++;
         end
         if (req_i && gnt_o) sent++;
         cyc++;
      end
      chk("stream_done", 32'(got), 32'(n));
      @(negedge clk); idle_inputs();
   endtask

   vec_t tbl [15];

   initial begin
      // req opa opb tag | drdy dval dres rrdy || gnt den dopa dtag cnt rval rdata rtag
      tbl[0]  = v(1, 100,  7,  3, 0, 0,  0, 1,  1, 0,   0,  0, 0, 0,  0, 0);
      tbl[1]  = v(0,   0,  0,  0, 1, 0,  0, 1,  1, 1, 100,  3, 1, 0,  0, 0);
      tbl[2]  = v(0,   0,  0,  0, 1, 0,  0, 1,  1, 0,   0,  0, 0, 0,  0, 0);
      tbl[3]  = v(0,   0,  0,  3, 0, 1, 14, 0,  1, 0,   0,  0, 0, 0,  0, 0);
      tbl[4]  = v(0,   0,  0,  0, 1, 0,  0, 0,  1, 0,   0,  0, 0, 1, 14, 3);
      tbl[5]  = v(0,   0,  0,  0, 1, 0,  0, 1,  1, 0,   0,  0, 0, 1, 14, 3);
      tbl[6]  = v(0,   0,  0,  0, 0, 0,  0, 1,  1, 0,   0,  0, 0, 0, 14, 3);
      tbl[7]  = v(1, 100, 10, 10, 0, 0,  0, 1,  1, 0,   0,  0, 0, 0, 14, 3);
      tbl[8]  = v(1, 110, 11, 11, 0, 0,  0, 1,  1, 0, 100, 10, 1, 0, 14, 3);
      tbl[9]  = v(1, 120, 12, 12, 0, 0,  0, 1,  1, 0, 100, 10, 2, 0, 14, 3);
      tbl[10] = v(1, 130, 13, 13, 0, 0,  0, 1,  1, 0, 100, 10, 3, 0, 14, 3);
      tbl[11] = v(1, 140, 14, 14, 0, 0,  0, 1,  0, 0, 100, 10, 4, 0, 14, 3);
      tbl[12] = v(1, 140, 14, 14, 1, 0,  0, 1,  0, 1, 100, 10, 4, 0, 14, 3);
      tbl[13] = v(1, 140, 14, 14, 0, 0,  0, 1,  1, 0, 110, 11, 3, 0, 14, 3);
      tbl[14] = v(0,   0,  0,  0, 0, 0,  0, 1,  0, 0, 110, 11, 4, 0, 14, 3);

      idle_inputs(); rst_n = 0;
      @(negedge clk); @(negedge clk); #1;
      chk("rst_gnt", gnt_o, 1); chk("rst_den", div_en_o, 0); chk("rst_rvalid", rvalid_o, 0);
      chk("rst_cnt", cnt_o, 0); chk("rst_rdata", rdata_o, 0); chk("rst_rtag", rtag_o, 0);
      chk("rst_dopa", div_opa_o, 0);
      @(negedge clk); rst_n = 1;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         req_i = tbl[i].req; op_i = 3'd1; opa_i = tbl[i].opa; opb_i = tbl[i].opb; tag_i = tbl[i].tag;
         div_ready_i = tbl[i].dready; div_valid_i = tbl[i].dvalid; div_res_i = tbl[i].dres;
         div_tag_i = tbl[i].tag; rready_i = tbl[i].rready;
         #1;
         chk($sformatf("v%0d_gnt", i), gnt_o, tbl[i].e_gnt);
         chk($sformatf("v%0d_den", i), div_en_o, tbl[i].e_den);
         chk($sformatf("v%0d_dopa", i), div_opa_o, tbl[i].e_dopa);
         chk($sformatf("v%0d_dtag", i), div_tag_o, tbl[i].e_dtag);
         chk($sformatf("v%0d_cnt", i), cnt_o, tbl[i].e_cnt);
         chk($sformatf("v%0d_rvalid", i), rvalid_o, tbl[i].e_rvalid);
         chk($sformatf("v%0d_rdata", i), rdata_o, tbl[i].e_rdata);
         chk($sformatf("v%0d_rtag", i), rtag_o, tbl[i].e_rtag);
      end

      // Results held back by the consumer, then a 9-request run that wraps the pointers
      do_reset(); run_stream(3, 25);
      do_reset(); run_stream(9, 0);

      // Push and issue in the same cycle with two queued
      do_reset();
      @(negedge clk); req_i = 1; tag_i = 1; opa_i = 11; opb_i = 1; div_ready_i = 0;
      @(negedge clk); tag_i = 2; opa_i = 22;
      @(negedge clk); tag_i = 3; opa_i = 33; div_ready_i = 1; #1;
      chk("pi_cnt_before", cnt_o, 2); chk("pi_den", div_en_o, 1); chk("pi_gnt", gnt_o, 1);
      chk("pi_dtag", div_tag_o, 1);
      @(negedge clk); req_i = 0; div_ready_i = 0; #1;
      chk("pi_cnt_after", cnt_o, 2); chk("pi_head", div_tag_o, 2); chk("pi_busy_den", div_en_o, 0);

      // Asynchronous reset while busy with two queued
      #2 rst_n = 0; #1;
      chk("ar_gnt", gnt_o, 1); chk("ar_cnt", cnt_o, 0); chk("ar_rvalid", rvalid_o, 0);
      chk("ar_den", div_en_o, 0);
      @(negedge clk); div_valid_i = 1; div_res_i = 99; div_tag_i = 7;
      @(negedge clk); div_valid_i = 0; rst_n = 1;
      @(negedge clk); #1;
      chk("ar_stray_rvalid", rvalid_o, 0); chk("ar_stray_cnt", cnt_o, 0); chk("ar_stray_rdata", rdata_o, 0);

      // Idle and empty: REM -7 % 3
      @(negedge clk); req_i = 1; op_i = 3'd2; opa_i = 32'hFFFF_FFF9; opb_i = 3; tag_i = 9;
      div_ready_i = 1; rready_i = 1; #1;
`ifdef DIV_ISSUE_BYPASS_EN
      chk("byp_den", div_en_o, 1); chk("byp_dopa", div_opa_o, 32'hFFFF_FFF9); chk("byp_dtag", div_tag_o, 9);
      @(negedge clk); req_i = 0; #1;
      chk("byp_cnt", cnt_o, 0); chk("byp_den_after", div_en_o, 0);
`else
      chk("nobyp_den", div_en_o, 0);
      @(negedge clk); req_i = 0; #1;
      chk("nobyp_den_next", div_en_o, 1); chk("nobyp_dopa", div_opa_o, 32'hFFFF_FFF9);
      chk("nobyp_dtag", div_tag_o, 9); chk("nobyp_dop", div_op_o, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
